complex_mul_pipe: RTL and testbench

Pipelined, parametrised complex arithmetic unit for the MFCC datapath. It performs add, subtract, multiply, conjugate-multiply and power (|a|²) on signed fixed-point complex operands. Multiply results use round-half-up and saturation rather than wrap-around. It has a valid/ready stream interface with full backpressure and sits between the FFT butterfly stage and the power-spectrum / mel-filter stages.

---
 rtl/complex_mul_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_complex_mul_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mul_pipe.sv
// complex_mul_pipe: three-stage complex arithmetic unit (add, sub, mul,
// conjugate-mul, power) on signed fixed-point operands with round-half-up,
// saturation and a valid/ready stream interface with full backpressure.
module complex_mul_pipe #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_W-1:0]     a_re,
  input  logic [DATA_W-1:0]     a_im,
  input  logic [DATA_W-1:0]     b_re,
  input  logic [DATA_W-1:0]     b_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     y_re,
  output logic [DATA_W-1:0]     y_im,
  output logic [2*DATA_W-1:0]   y_pow,
  output logic                  sat,
  output logic                  sat_sticky,
  input  logic                  sat_clr
);

  localparam int PW = 2 * DATA_W;   // full product width
  localparam int RW = DATA_W + 2;   // rounded / combined width

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_CMUL = 3'd3;
  localparam logic [2:0] OP_POW  = 3'd4;

  // Rounding constant 2^(FRAC_W-1) at product width plus one guard bit.
  localparam logic signed [PW:0] HALF =
    {{(PW-FRAC_W+1){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] YMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] YMIN = {1'b1, {(DATA_W-1){1'b0}}};

  // One enable moves the whole pipe; a stalled output freezes every stage.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------- S1
  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0] m0, m1, m2, m3;

  assign ar_x = PW'($signed(a_re));
  assign ai_x = PW'($signed(a_im));
  assign br_x = PW'($signed(b_re));
  assign bi_x = PW'($signed(b_im));

  // Product selection: squares of a for POWER, cross products otherwise.
  always_comb begin
    if (op == OP_POW) begin
      m0 = ar_x * ar_x;
      m1 = ai_x * ai_x;
      m2 = '0;
      m3 = '0;
    end else begin
      m0 = ar_x * br_x;   // rr
      m1 = ai_x * bi_x;   // ii
      m2 = ar_x * bi_x;   // ri
      m3 = ai_x * br_x;   // ir
    end
  end

  logic                     s1_valid;
  logic [2:0]               s1_op;
  logic signed [DATA_W-1:0] s1_ar, s1_ai, s1_br, s1_bi;
  logic signed [PW-1:0]     s1_p0, s1_p1, s1_p2, s1_p3;

  // Stage 1 register: operands and products, loaded only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_ar    <= '0;
      s1_ai    <= '0;
      s1_br    <= '0;
      s1_bi    <= '0;
      s1_p0    <= '0;
      s1_p1    <= '0;
      s1_p2    <= '0;
      s1_p3    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= op;
        s1_ar <= $signed(a_re);
        s1_ai <= $signed(a_im);
        s1_br <= $signed(b_re);
        s1_bi <= $signed(b_im);
        s1_p0 <= m0;
        s1_p1 <= m1;
        s1_p2 <= m2;
        s1_p3 <= m3;
      end
    end
  end

  // ---------------------------------------------------------------- S2
  // Round half up: add half an LSB, then arithmetic shift out the fraction.
  function automatic logic signed [RW-1:0] rnd(input logic signed [PW-1:0] p);
    logic signed [PW:0] t;
    t = (PW+1)'(p) + HALF;
    return RW'(t >>> FRAC_W);
  endfunction

  logic signed [RW-1:0] rr, ii, ri, ir;
  logic signed [RW-1:0] re_c, im_c;
  logic [PW-1:0]        pow_c;

  // Combine rounded products or extended operands according to the opcode.
  always_comb begin
    rr    = rnd(s1_p0);
    ii    = rnd(s1_p1);
    ri    = rnd(s1_p2);
    ir    = rnd(s1_p3);
    re_c  = '0;
    im_c  = '0;
    pow_c = '0;
    case (s1_op)
      OP_ADD: begin
        re_c = RW'(s1_ar) + RW'(s1_br);
        im_c = RW'(s1_ai) + RW'(s1_bi);
      end
      OP_SUB: begin
        re_c = RW'(s1_ar) - RW'(s1_br);
        im_c = RW'(s1_ai) - RW'(s1_bi);
      end
      OP_MUL: begin
        re_c = rr - ii;
        im_c = ri + ir;
      end
      OP_CMUL: begin
        re_c = rr + ii;
        im_c = ir - ri;
      end
      OP_POW: begin
        // Squares are non-negative, so their unsigned sum fits in PW bits.
        pow_c = $unsigned(s1_p0) + $unsigned(s1_p1);
      end
      default: ;
    endcase
  end

  logic                 s2_valid;
  logic signed [RW-1:0] s2_c [2];
  logic [PW-1:0]        s2_pow;

  // Stage 2 register: unsaturated real/imag lanes and the power sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_c[0]  <= '0;
      s2_c[1]  <= '0;
      s2_pow   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_c[0] <= re_c;
        s2_c[1] <= im_c;
        s2_pow  <= pow_c;
      end
    end
  end

  // ---------------------------------------------------------------- S3
  logic [1:0][DATA_W-1:0] lane_y;
  logic [1:0]             lane_hi, lane_lo;

  for (genvar gi = 0; gi < 2; gi++) begin : g_sat
    assign lane_hi[gi] = s2_c[gi] > RW'(YMAX);
    assign lane_lo[gi] = s2_c[gi] < RW'(YMIN);
    assign lane_y[gi]  = lane_hi[gi] ? YMAX :
                         lane_lo[gi] ? YMIN : s2_c[gi][DATA_W-1:0];
  end

  logic sat_c;
  assign sat_c = |(lane_hi | lane_lo);

  // Output register: saturated result beat, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y_re      <= '0;
      y_im      <= '0;
      y_pow     <= '0;
      sat       <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        y_re  <= lane_y[0];
        y_im  <= lane_y[1];
        y_pow <= s2_pow;
        sat   <= sat_c;
      end
    end
  end

  // Sticky saturation flag; a new saturating beat wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_sticky <= 1'b0;
    end else if (en && s2_valid && sat_c) begin
      sat_sticky <= 1'b1;
    end else if (sat_clr) begin
      sat_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_complex_mul_pipe.sv
// tb_complex_mul_pipe: scoreboard bench for complex_mul_pipe. The driver
// pushes expected results from an integer reference model; an independent
// monitor pops and compares whenever a result beat is transferred.
module tb_complex_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a_re, a_im, b_re, b_im;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y_re, y_im;
  logic [63:0] y_pow;
  logic        sat;
  logic        sat_sticky;
  logic        sat_clr;

  always #5 clk = ~clk;

  complex_mul_pipe #(.DATA_W(32), .FRAC_W(31)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a_re       (a_re),
    .a_im       (a_im),
    .b_re       (b_re),
    .b_im       (b_im),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y_re       (y_re),
    .y_im       (y_im),
    .y_pow      (y_pow),
    .sat        (sat),
    .sat_sticky (sat_sticky),
    .sat_clr    (sat_clr)
  );

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [63:0] pow;
    logic        sat;
    int          acc;
    bit          chk;
  } exp_t;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pops = 0;
  bit   free_run = 1'b1;
  bit   rnd_on = 1'b0;
  exp_t q[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Round half up of a Q1.31 x Q1.31 product back to Q1.31 scale.
  function automatic longint rnd(input longint p);
    return (p + 64'sd1073741824) >>> 31;
  endfunction

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] ar_u,
                                 input logic [31:0] ai_u, input logic [31:0] br_u,
                                 input logic [31:0] bi_u);
    longint ar, ai, br, bi, re, im;
    exp_t   e;
    ar = longint'($signed(ar_u));
    ai = longint'($signed(ai_u));
    br = longint'($signed(br_u));
    bi = longint'($signed(bi_u));
    re = 0;
    im = 0;
    e.pow = 64'd0;
    e.sat = 1'b0;
    e.acc = 0;
    e.chk = 1'b0;
    case (o)
      3'd0: begin re = ar + br; im = ai + bi; end
      3'd1: begin re = ar - br; im = ai - bi; end
      3'd2: begin re = rnd(ar * br) - rnd(ai * bi); im = rnd(ar * bi) + rnd(ai * br); end
      3'd3: begin re = rnd(ar * br) + rnd(ai * bi); im = rnd(ai * br) - rnd(ar * bi); end
      3'd4: e.pow = 64'(ar * ar) + 64'(ai * ai);
      default: ;
    endcase
    if (re > MAXV) begin re = MAXV; e.sat = 1'b1; end
    else if (re < MINV) begin re = MINV; e.sat = 1'b1; end
    if (im > MAXV) begin im = MAXV; e.sat = 1'b1; end
    else if (im < MINV) begin im = MINV; e.sat = 1'b1; end
    e.re = re[31:0];
    e.im = im[31:0];
    return e;
  endfunction

  task automatic push_exp(input logic [2:0] o, input logic [31:0] ar, input logic [31:0] ai,
                          input logic [31:0] br, input logic [31:0] bi);
    exp_t e;
    e = model(o, ar, ai, br, bi);
    e.acc = cyc;
    e.chk = free_run;
    q.push_back(e);
  endtask

  // Present one beat and hold it until accepted; returns just after the edge.
  task automatic send(input logic [2:0] o, input logic [31:0] ar, input logic [31:0] ai,
                      input logic [31:0] br, input logic [31:0] bi);
    int waited = 0;
    in_valid = 1'b1;
    op = o;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(o, ar, ai, br, bi);
        break;
      end
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 64'(in_ready), 64'd1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 5))
      0: return 32'h80000000;
      1: return 32'h7FFFFFFF;
      2: return 32'h40000000;
      default: return $urandom();
    endcase
  endfunction

  // Monitor: one comparison line per transferred result beat.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%h_%h required=no_beat", y_re, y_im);
      end else begin
        mon_e = q.pop_front();
        check("y_re", 64'(y_re), 64'(mon_e.re));
        check("y_im", 64'(y_im), 64'(mon_e.im));
        check("y_pow", y_pow, mon_e.pow);
        check("sat", 64'(sat), 64'(mon_e.sat));
        if (mon_e.chk) check("latency", 64'(cyc - mon_e.acc), 64'd3);
        pops++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] bpv [6][4];
  logic [31:0] s_re, s_im;
  logic [63:0] s_pow;
  int          idx;
  int          pb;
  int          n;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 3'd0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    out_ready = 1'b1; sat_clr = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_y_re", 64'(y_re), 64'd0);
    check("rst_y_im", 64'(y_im), 64'd0);
    check("rst_y_pow", y_pow, 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    check("rst_sticky", 64'(sat_sticky), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_empty", 64'(in_ready), 64'd1);

    // Directed beats that must not saturate.
    send(3'd2, 32'h40000000, 32'h0, 32'h40000000, 32'h0);
    send(3'd2, 32'h00000001, 32'h0, 32'h40000000, 32'h0);
    send(3'd2, 32'hFFFFFFFF, 32'h0, 32'h40000000, 32'h0);
    send(3'd3, 32'h0, 32'h40000000, 32'h0, 32'h40000000);
    send(3'd4, 32'h80000000, 32'h80000000, 32'h12345678, 32'h9ABCDEF0);
    send(3'd6, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    drain();
    check("sticky_clean", 64'(sat_sticky), 64'd0);

    // Saturating multiply, then clear the sticky flag.
    send(3'd2, 32'h80000000, 32'h0, 32'h80000000, 32'h0);
    drain();
    check("sticky_set", 64'(sat_sticky), 64'd1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("sticky_clr", 64'(sat_sticky), 64'd0);

    // Saturating add/sub on both lanes.
    send(3'd0, 32'h7FFFFFFF, 32'h80000000, 32'h00000001, 32'hFFFFFFFF);
    send(3'd1, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 32'hFFFFFFFF);
    drain();
    check("sticky_set2", 64'(sat_sticky), 64'd1);

    // Clear held high while a saturating beat lands: set wins.
    sat_clr = 1'b1;
    send(3'd2, 32'h80000000, 32'h0, 32'h80000000, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check("setwin_valid", 64'(out_valid), 64'd1);
    check("setwin_sticky", 64'(sat_sticky), 64'd1);
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("setwin_cleared", 64'(sat_sticky), 64'd0);
    drain();

    // Backpressure: six MUL beats against a stalled output.
    free_run = 1'b0;
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 4; j++) bpv[k][j] = rv();
    pb = pops;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; op = 3'd2;
      a_re = bpv[idx][0]; a_im = bpv[idx][1]; b_re = bpv[idx][2]; b_im = bpv[idx][3];
      @(negedge clk);
      if (in_ready) begin
        push_exp(3'd2, bpv[idx][0], bpv[idx][1], bpv[idx][2], bpv[idx][3]);
        idx++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepts", 64'(idx), 64'd3);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    s_re = y_re; s_im = y_im; s_pow = y_pow;
    repeat (2) begin
      @(negedge clk);
      check("bp_hold_re", 64'(y_re), 64'(s_re));
      check("bp_hold_im", 64'(y_im), 64'(s_im));
      check("bp_hold_pow", y_pow, s_pow);
      check("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = idx; k < 6; k++) send(3'd2, bpv[k][0], bpv[k][1], bpv[k][2], bpv[k][3]);
    drain();
    check("bp_all_out", 64'(pops - pb), 64'd6);

    // Reset in the middle of a stalled stream discards everything in flight.
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 4; j++) bpv[k][j] = rv();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; op = 3'd2;
      a_re = bpv[idx][0]; a_im = bpv[idx][1]; b_re = bpv[idx][2]; b_im = bpv[idx][3];
      @(negedge clk);
      if (in_ready) begin
        push_exp(3'd2, bpv[idx][0], bpv[idx][1], bpv[idx][2], bpv[idx][3]);
        idx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_y_re", 64'(y_re), 64'd0);
    check("mrst_y_im", 64'(y_im), 64'd0);
    check("mrst_y_pow", y_pow, 64'd0);
    check("mrst_sat", 64'(sat), 64'd0);
    check("mrst_sticky", 64'(sat_sticky), 64'd0);
    q.delete();
    pb = pops;
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mrst_no_out", 64'(pops - pb), 64'd0);
    check("mrst_out_valid2", 64'(out_valid), 64'd0);
    check("mrst_in_ready", 64'(in_ready), 64'd1);

    // Random ops, operands, gaps and output stalls.
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      send(3'($urandom_range(0, 7)), rv(), rv(), rv(), rv());
    end
    rnd_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
